uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Receive half of the user-project UART, the far end of the testbench UART transmitter driving mprj_io[5].
- Deserialises 8N1 frames from an asynchronous serial line.
- Received bytes go into a small FIFO, popped by the user logic over a valid/ready interface.
- Reports framing and overrun errors as sticky flags, cleared by the user logic.

Parameters:
- CLKS_PER_BIT, 4167, clock cycles per serial bit (40 MHz / 9600 baud); must be >= 8.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.
- CNT_W, 13, width of the bit-period counter; must hold CLKS_PER_BIT-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- rx  input  1  asynchronous serial input; idle high.
- rx_data  output  8  byte at FIFO head; valid only while rx_valid=1.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  consumer accepts head byte this cycle.
- rx_count  output  $clog2(FIFO_DEPTH)+1  bytes currently held.
- frame_err  output  1  sticky: stop bit sampled low.
- overrun_err  output  1  sticky: byte completed while FIFO full and no pop.
- err_clear  input  1  one-cycle pulse clears both sticky flags.
- rx_busy  output  1  receiver not in IDLE.

Behaviour:
- Reset: rst_n sampled low at a clk edge forces the following, regardless of any frame in progress:
  - FSM to IDLE; FIFO empty.
  - rx_valid=0, rx_count=0, rx_data=0.
  - frame_err=0, overrun_err=0, rx_busy=0.
  - Both synchroniser flops set to 1.
- Synchroniser: rx passes through 2 flops (rx_s); only rx_s is used by the FSM.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rx_s==0 -> START, bit counter cleared.
  - START: at count==CLKS_PER_BIT/2-1 (integer division), sample rx_s.
    - rx_s==0 -> DATA, count=0, bit index=0.
    - rx_s==1 -> IDLE (glitch rejected; no flags change).
  - DATA: every CLKS_PER_BIT cycles sample rx_s into shift register, LSB first. After bit index 7 -> STOP.
  - STOP: after CLKS_PER_BIT cycles sample rx_s.
    - rx_s==1: push byte, -> IDLE.
    - rx_s==0: set frame_err, discard byte, -> BREAK.
  - BREAK: wait for rx_s==1, then -> IDLE. A held-low line produces exactly one frame_err.
- rx_busy = (state != IDLE).
- Push timing: byte becomes visible (rx_valid=1, rx_data) on the cycle after the stop-bit sample edge.
  - Nominal: falling edge of rx to rx_valid = 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, ±1.
- FIFO:
  - rx_data = head entry (registered storage, combinational read).
  - Pop when rx_valid && rx_ready; rx_ready while empty is ignored.
  - Push and pop in the same cycle: both occur, rx_count unchanged. This holds when full: no overrun, new byte stored.
  - Push while full with no pop: byte dropped, overrun_err set, FIFO contents unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH; rx_count ranges 0..FIFO_DEPTH.
- Error flags:
  - Set has priority over err_clear in the same cycle: flag stays 1.
  - err_clear has no effect on FSM or FIFO.
- Next start edge is accepted in IDLE immediately after the stop-bit sample. Back-to-back frames with a single stop bit must be received without loss.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
- Reset then idle line for 200 cycles -> rx_valid=0, rx_count=0, both flags 0, rx_busy=0 throughout.
- Send 0x3D with rx_ready=0 -> rx_valid rises 155±1 cycles after start edge, rx_data=0x3D, rx_count=1. Pulse rx_ready one cycle -> rx_valid=0, rx_count=0.
- Send 0x3D, 0x0F, 0xAB, 0x51 back-to-back with rx_ready=0 -> rx_count=4. Send 0xFF -> overrun_err=1, rx_count=4. Pop four times -> 0x3D, 0x0F, 0xAB, 0x51 in order.
- With FIFO full, hold rx_ready=1 while a fifth byte 0x22 completes -> no overrun_err. Popped sequence ends with 0x22.
- Frame 0x55 with stop bit driven low, line then held low 100 cycles -> frame_err=1 once, no push, rx_busy=1 until rx high. err_clear pulse -> frame_err=0. Next frame 0xA5 received correctly.
- 4-cycle low glitch on idle line -> returns to IDLE, no push, no flags. Then assert rst_n=0 mid-frame for 1 cycle -> all outputs at reset values. The remaining bits of the interrupted frame must not produce a valid byte unless they form a full frame.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Receive-side UART bus: serial line in, FIFO pop handshake and error flags out.
// slave  = the receiver (uart_rx_fifo)
// master = the consumer / line driver
interface uart_rx_fifo_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          rx;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [CW-1:0] rx_count;
   logic          frame_err;
   logic          overrun_err;
   logic          err_clear;
   logic          rx_busy;

   modport slave (
      input  rx, rx_ready, err_clear,
      output rx_data, rx_valid, rx_count, frame_err, overrun_err, rx_busy
   );

   modport master (
      output rx, rx_ready, err_clear,
      input  rx_data, rx_valid, rx_count, frame_err, overrun_err, rx_busy
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small receive FIFO and sticky framing/overrun flags.
// The serial input is double-synchronised; a mid-bit sampling FSM assembles
// bytes LSB first and hands each completed byte to the FIFO one cycle after
// the stop-bit sample.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 4167,
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_W        = 13
) (
   input logic           clk,
   input logic           rst_n,
   uart_rx_fifo_if.slave bus
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]    DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   // synchroniser
   logic sync1_q;
   logic rx_s_q;

   // receiver FSM state and registered outputs
   state_t     state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0] bit_idx_q;
   logic [7:0] shift_q;
   logic       push_q;
   logic [7:0] push_data_q;
   logic       frame_err_q;
   logic       busy_q;

   // FIFO
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          overrun_q;
   logic          pop;
   logic          full;
   logic          wr_en;
   logic          overrun_set;

   // Two-flop synchroniser; idles high so reset never looks like a start bit
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         sync1_q <= bus.rx;
         rx_s_q  <= sync1_q;
      end
   end

   // Receiver FSM: start validation at half bit, then one sample per bit period
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         push_q      <= 1'b0;
         push_data_q <= '0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         push_q <= 1'b0;
         // a framing error raised below overrides this clear
         if (bus.err_clear) begin
            frame_err_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (!rx_s_q) begin
                  state_q <= S_START;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_START: begin
               if (cnt_q == HALF_M1) begin
                  cnt_q <= '0;
                  if (!rx_s_q) begin
                     state_q   <= S_DATA;
                     bit_idx_q <= '0;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_s_q, shift_q[7:1]};
                  if (bit_idx_q == 3'd7) begin
                     state_q <= S_STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_STOP: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q <= '0;
                  if (rx_s_q) begin
                     push_q      <= 1'b1;
                     push_data_q <= shift_q;
                     state_q     <= S_IDLE;
                     busy_q      <= 1'b0;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= S_BREAK;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_BREAK: begin
               // a line held low reports a single framing error, not one per frame time
               if (rx_s_q) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // A simultaneous pop frees the slot, so a push into a full FIFO still lands
   assign pop         = (count_q != '0) && bus.rx_ready;
   assign full        = (count_q == DEPTH_C);
   assign wr_en       = push_q && (!full || pop);
   assign overrun_set = push_q && full && !pop;

   // Occupancy next-state from push/pop combination
   always_comb begin
      count_d = count_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO storage write; contents need no reset because pointers define validity
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         mem_q[wr_ptr_q] <= push_data_q;
      end
   end

   // FIFO pointers, occupancy and sticky overrun flag (set wins over clear)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
         if (overrun_set) begin
            overrun_q <= 1'b1;
         end else if (bus.err_clear) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign bus.rx_valid    = (count_q != '0);
   assign bus.rx_data     = bus.rx_valid ? mem_q[rd_ptr_q] : 8'h00;
   assign bus.rx_count    = count_q;
   assign bus.frame_err   = frame_err_q;
   assign bus.overrun_err = overrun_q;
   assign bus.rx_busy     = busy_q;

endmodule
